// File: rtl/fpu_arbiter_pkg.sv
// fpu_arbiter_pkg: shared operand/opcode widths, FSM state encoding and port-mask helper for the FPU arbiter
package fpu_arbiter_pkg;
  localparam int REG_SIZE = 32;
  localparam int OP_BITS = 4;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;
  function automatic logic [1:0] port_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/fpu_arbiter_rr.sv
// rr_arb2: combinational 2-way round-robin pick; req in, last (1 = port 1 granted last) in, one-hot gnt and winner index win out
module rr_arb2
  import fpu_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       win
);
  always_comb begin
    win = &req ? ~last : req[1];
    gnt = |req ? port_mask(win) : 2'b00;
  end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU between two requesters; ports clk/rst, req/a0/b0/op0/a1/b1/op1 in, gnt/done/err/res out, fpu_start/fpu_inpA/fpu_inpB/fpu_op out, fpu_res/fpu_ready in
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int W = REG_SIZE,
  parameter int OW = OP_BITS,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  b0,
  input  logic [OW-1:0] op0,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  b1,
  input  logic [OW-1:0] op1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [W-1:0]  res,
  output logic          fpu_start,
  output logic [W-1:0]  fpu_inpA,
  output logic [W-1:0]  fpu_inpB,
  output logic [OW-1:0] fpu_op,
  input  logic [W-1:0]  fpu_res,
  input  logic          fpu_ready
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
  state_t state, state_n;
  logic last, win, take, waiting, complete, abort;
  logic [1:0] pick;
  logic [CW-1:0] cnt;
  rr_arb2 u_rr (
    .req (req),
    .last(last),
    .gnt (pick),
    .win (win)
  );
  always_comb begin
    take = state == IDLE && |req;
    waiting = state == WAIT_BUSY || state == WAIT_DONE;
    complete = state == WAIT_DONE && fpu_ready;
    abort = waiting && cnt == CNT_LAST && !complete;
    state_n = state;
    case (state)
      IDLE:      state_n = take ? ISSUE : IDLE;
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = abort ? RESP : fpu_ready ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: state_n = complete || abort ? RESP : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt <= 2'b00;
      done <= 2'b00;
      err <= 1'b0;
      res <= '0;
      fpu_start <= 1'b0;
      fpu_inpA <= '0;
      fpu_inpB <= '0;
      fpu_op <= '0;
      cnt <= '0;
      last <= 1'b1;
    end else begin
      fpu_start <= take;
      done <= complete || abort ? gnt : 2'b00;
      cnt <= state == ISSUE ? '0 : waiting ? cnt + 1'b1 : cnt;
      if (take) begin
        gnt <= pick;
        last <= win;
        fpu_inpA <= win ? a1 : a0;
        fpu_inpB <= win ? b1 : b0;
        fpu_op <= win ? op1 : op0;
      end
      if (complete || abort) begin
        res <= complete ? fpu_res : '0;
        err <= !complete;
      end
      if (state == RESP) gnt <= 2'b00;
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: scoreboarded directed + random bench for fpu_arbiter against an XOR FPU model
module tb_fpu_arbiter;
  localparam int W = 32;
  localparam int OW = 4;
  localparam int T = 16;
  localparam int LAT = 9;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [OW-1:0] op0 = '0, op1 = '0;
  logic [1:0] gnt, done;
  logic err, fpu_start, fpu_ready;
  logic [W-1:0] res, fpu_inpA, fpu_inpB, fpu_res;
  logic [OW-1:0] fpu_op;
  logic hang = 1'b0, rnd = 1'b0, m_last = 1'b1, start_q = 1'b0;
  logic [W-1:0] fa, fb, orig;
  int fc, total = 0, bad = 0, cyc = 0, free_at = 0, n;
  int n_done[2] = '{0, 0};
  typedef struct {
    int port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [OW-1:0] op;
    logic [W-1:0] r;
    logic e;
    int at;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  fpu_arbiter #(.W(W), .OW(OW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt(gnt), .done(done), .err(err), .res(res),
    .fpu_start(fpu_start), .fpu_inpA(fpu_inpA), .fpu_inpB(fpu_inpB), .fpu_op(fpu_op),
    .fpu_res(fpu_res), .fpu_ready(fpu_ready)
  );
  // FPU: ready falls two edges after start is seen, rises five edges later with A^B (never while hang)
  always @(posedge clk) begin
    if (!rst) begin
      fpu_ready <= 1'b1;
      fc <= 0;
      fpu_res <= '0;
    end else if (fpu_start) begin
      fc <= 1;
      fa <= fpu_inpA;
      fb <= fpu_inpB;
    end else if (fc == 2) begin
      fpu_ready <= 1'b0;
      fpu_res <= '1;
      fc <= 3;
    end else if (fc == 7) begin
      if (!hang) begin
        fpu_ready <= 1'b1;
        fpu_res <= fa ^ fb;
        fc <= 0;
      end
    end else if (fc != 0) fc <= fc + 1;
  end
  // reference: one transaction at a time, round-robin between pending ports, fixed latency
  always @(posedge clk) begin
    exp_t x;
    if (!rst) begin
      sb.delete();
      m_last = 1'b1;
      free_at = cyc + 1;
    end else if (cyc >= free_at && req != 2'b00) begin
      if (req == 2'b11) x.port = m_last ? 0 : 1;
      else x.port = req[1] ? 1 : 0;
      m_last = x.port == 1;
      x.a = x.port == 1 ? a1 : a0;
      x.b = x.port == 1 ? b1 : b0;
      x.op = x.port == 1 ? op1 : op0;
      x.r = hang ? '0 : x.a ^ x.b;
      x.e = hang;
      x.at = cyc + (hang ? T : LAT) + 1;
      free_at = cyc + (hang ? T : LAT) + 2;
      sb.push_back(x);
    end
    cyc = cyc + 1;
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst) start_q = 1'b0;
    else begin
      chk("gnt_two_hot", {31'd0, gnt == 2'b11}, 0);
      if (fpu_start) begin
        chk("start_single_cycle", {31'd0, start_q}, 0);
        if (sb.size() == 0) chk("start_without_grant", 1, 0);
        else begin
          x = sb[$];
          chk("start_gnt", gnt, x.port == 1 ? 2'b10 : 2'b01);
          chk("start_inpA", fpu_inpA, x.a);
          chk("start_inpB", fpu_inpB, x.b);
          chk("start_op", fpu_op, x.op);
        end
      end
      start_q = fpu_start;
      if (done != 2'b00) begin
        if (sb.size() == 0) chk("unexpected_done", done, 0);
        else begin
          x = sb.pop_front();
          n_done[x.port]++;
          chk("done_port", done, x.port == 1 ? 2'b10 : 2'b01);
          chk("done_owner", gnt, done);
          chk("done_res", res, x.r);
          chk("done_err", {31'd0, err}, {31'd0, x.e});
          chk("done_cycle", cyc, x.at);
        end
      end
    end
  end
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (done[p]) req[p] = 1'b0;
        else if (rnd && !req[p] && $urandom_range(3) == 0) begin
          if (p == 0) begin
            a0 = $urandom; b0 = $urandom; op0 = OW'($urandom_range(15));
          end else begin
            a1 = $urandom; b1 = $urandom; op1 = OW'($urandom_range(15));
          end
          req[p] = 1'b1;
        end
      end
    end
  endtask
  task automatic wait_done(input int lim, output int k);
    k = 0;
    while (done == 2'b00 && k < lim) begin
      step(1);
      k++;
    end
  endtask
  task automatic drain(input int lim);
    int k = 0;
    while ((req != 2'b00 || sb.size() != 0) && k < lim) begin
      step(1);
      k++;
    end
    chk("drain_in_time", {31'd0, k >= lim}, 0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req = 2'b00;
    step(2);
    rst = 1'b1;
  endtask
  initial begin
    step(3);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_start", {31'd0, fpu_start}, 0);
    chk("rst_res", res, 0);
    chk("rst_inpA", fpu_inpA, 0);
    chk("rst_inpB", fpu_inpB, 0);
    chk("rst_op", fpu_op, 0);
    rst = 1'b1;
    a0 = 32'h3F800000; b0 = 32'h40000000; op0 = 4'h2;
    req = 2'b01;
    step(1);
    chk("single_gnt", gnt, 2'b01);
    wait_done(40, n);
    chk("single_latency", n, LAT);
    chk("single_done", done, 2'b01);
    chk("single_res", res, 32'h7F800000);
    chk("single_err", {31'd0, err}, 0);
    drain(40);
    do_reset();
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; op0 = 4'h5; op1 = 4'hA;
    req = 2'b11;
    step(1);
    chk("both_first_port0", gnt, 2'b01);
    n = 0;
    while (gnt != 2'b10 && n < 40) begin
      step(1);
      n++;
    end
    chk("both_second_port1", gnt, 2'b10);
    orig = a1;
    a1 = '1;
    step(1);
    chk("operand_held", fpu_inpA, orig);
    drain(40);
    a0 = $urandom; a1 = $urandom;
    req = 2'b11;
    step(1);
    chk("third_round_port0", gnt, 2'b01);
    drain(60);
    hang = 1'b1;
    a1 = $urandom; b1 = $urandom;
    req = 2'b10;
    step(1);
    wait_done(60, n);
    chk("timeout_latency", n, T);
    chk("timeout_err", {31'd0, err}, 1);
    chk("timeout_res", res, 0);
    drain(40);
    hang = 1'b0;
    a0 = $urandom; b0 = $urandom;
    req = 2'b01;
    step(1);
    wait_done(40, n);
    chk("after_timeout_latency", n, LAT);
    chk("after_timeout_err", {31'd0, err}, 0);
    drain(40);
    a0 = $urandom;
    req = 2'b01;
    step(1);
    n = 0;
    while (fpu_ready && n < 20) begin
      step(1);
      n++;
    end
    step(1);
    n = n_done[0];
    rst = 1'b0;
    step(1);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_start", {31'd0, fpu_start}, 0);
    rst = 1'b1;
    req = 2'b00;
    step(20);
    chk("midrst_no_done", n_done[0], n);
    n = n_done[1];
    a0 = $urandom;
    req = 2'b01;
    step(3);
    req[1] = 1'b1;
    step(1);
    req[1] = 1'b0;
    drain(40);
    step(5);
    chk("withdraw_no_port1", n_done[1], n);
    chk("withdraw_idle", gnt, 0);
    rnd = 1'b1;
    step(800);
    rnd = 1'b0;
    drain(100);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
